// File: rtl/data_mem_responder.sv
// Banked word memory answering one load/store at a time over valid/ready,
// with a fixed access latency, byte/half/word lanes and request error flagging.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic        load_signed,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  rd_reg;
    logic [1:0]  wr_reg;
    logic        signed_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_data_reg;
    logic        resp_err_reg;

    logic [ADDR_W-1:0] mem_index;
    logic [31:0]       mem_rdata;
    logic              enter_resp;
    logic              commit;

    logic [1:0]  size;
    logic        cmd_err;
    logic        align_err;
    logic        range_err;
    logic        err;
    logic [ADDR_W:0] index_ext;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_value;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;

    // The read is issued from the live address on the accept edge so that the
    // registered RAM output is ready by the time the response is formed.
    assign mem_index  = (state_reg == IDLE) ? req_addr[ADDR_W+1:2] : addr_reg[ADDR_W+1:2];
    assign enter_resp = (state_reg == BUSY) && (count_reg == 4'd0);
    assign commit     = enter_resp && !reset && !err && (wr_reg != 2'b00);

    always_comb begin
        size      = rd_reg | wr_reg;
        index_ext = {1'b0, addr_reg[ADDR_W+1:2]};
        cmd_err   = ((rd_reg != 2'b00) == (wr_reg != 2'b00));
        align_err = ((size == 2'b10) && addr_reg[0]) ||
                    ((size == 2'b11) && (addr_reg[1:0] != 2'b00));
        range_err = (index_ext >= (ADDR_W+1)'(DEPTH_WORDS)) ||
                    (addr_reg[31:ADDR_W+2] != '0);
        err       = cmd_err || align_err || range_err;
    end

    always_comb begin
        lane_sel   = 4'b0000;
        lane_wdata = 32'h0;
        case (wr_reg)
            2'b01: begin
                lane_sel   = 4'b0001 << addr_reg[1:0];
                lane_wdata = {4{wdata_reg[7:0]}};
            end
            2'b10: begin
                lane_sel   = addr_reg[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_reg[15:0]}};
            end
            2'b11: begin
                lane_sel   = 4'b1111;
                lane_wdata = wdata_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted    = mem_rdata >> {addr_reg[1:0], 3'b000};
        load_value = 32'h0;
        case (rd_reg)
            2'b01: load_value = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
            2'b10: load_value = {{16{signed_reg & shifted[15]}}, shifted[15:0]};
            2'b11: load_value = mem_rdata;
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clk) begin
                if (commit && lane_sel[gi]) begin
                    lane_mem[addr_reg[ADDR_W+1:2]] <= lane_wdata[8*gi +: 8];
                end
                lane_rdata_reg <= lane_mem[mem_index];
            end

            assign mem_rdata[8*gi +: 8] = lane_rdata_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            rd_reg         <= 2'b00;
            wr_reg         <= 2'b00;
            signed_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg   <= req_addr;
                        wdata_reg  <= write_data;
                        rd_reg     <= mem_read;
                        wr_reg     <= mem_write;
                        signed_reg <= load_signed;
                        count_reg  <= 4'(WAIT_CYCLES);
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    // One BUSY cycle beyond the wait count covers the RAM read.
                    if (count_reg == 4'd0) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= err;
                        resp_data_reg  <= (err || rd_reg == 2'b00) ? 32'h0 : load_value;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_data_reg  <= 32'h0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized load/store
// traffic checked against a byte-array reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, load_signed;
    logic [31:0] req_addr, write_data, resp_data;
    logic [1:0]  mem_read, mem_write;
    logic        resp_valid, resp_ready, resp_err;

    logic        z_req_valid, z_req_ready, z_load_signed;
    logic [31:0] z_req_addr, z_write_data, z_resp_data;
    logic [1:0]  z_mem_read, z_mem_write;
    logic        z_resp_valid, z_resp_ready, z_resp_err;

    data_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .mem_read(mem_read), .mem_write(mem_write),
        .load_signed(load_signed), .write_data(write_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .WAIT_CYCLES(0)) z_dut (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_addr(z_req_addr), .mem_read(z_mem_read), .mem_write(z_mem_write),
        .load_signed(z_load_signed), .write_data(z_write_data), .resp_valid(z_resp_valid),
        .resp_ready(z_resp_ready), .resp_data(z_resp_data), .resp_err(z_resp_err)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] model_mem [1024];

    // Reference: byte-addressed memory, legality from size and address arithmetic.
    task automatic model_access(input logic [31:0] a, input logic [1:0] r, input logic [1:0] w,
                                input logic s, input logic [31:0] d,
                                output logic e, output logic [31:0] q);
        int n;
        logic [1:0] sz;
        e = 1'b0;
        q = 32'h0;
        if ((r != 2'b00) == (w != 2'b00)) e = 1'b1;
        sz = (r != 2'b00) ? r : w;
        n = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
        if (a >= 32'd1024) e = 1'b1;
        else if ((a % 32'(n)) != 0) e = 1'b1;
        if (!e) begin
            if (w != 2'b00) begin
                for (int k = 0; k < n; k++) model_mem[a + 32'(k)] = d[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) q[8*k +: 8] = model_mem[a + 32'(k)];
                if (s && n < 4 && q[8*n-1]) begin
                    for (int k = n; k < 4; k++) q[8*k +: 8] = 8'hFF;
                end
            end
        end
    endtask

    // Drives one request on the WAIT_CYCLES=2 instance and returns the response
    // and the number of edges from accept to resp_valid (99 if it never came).
    task automatic issue(input logic [31:0] a, input logic [1:0] r, input logic [1:0] w,
                         input logic s, input logic [31:0] d,
                         output logic [31:0] q, output logic e, output int lat);
        @(negedge clk);
        req_addr = a; mem_read = r; mem_write = w; load_signed = s; write_data = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; mem_read = 2'($urandom); mem_write = 2'($urandom);
        load_signed = 1'($urandom); write_data = $urandom;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            resp_ready = 1'($urandom);
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        q = resp_data;
        e = resp_err;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        $display("txn addr=%h rd=%0d wr=%0d sgn=%0d wdata=%h -> data=%h err=%0b lat=%0d",
                 a, r, w, s, d, q, e, lat);
    endtask

    task automatic issue_z(input logic [31:0] a, input logic [1:0] r, input logic [1:0] w,
                           input logic s, input logic [31:0] d,
                           output logic [31:0] q, output logic e, output int lat);
        @(negedge clk);
        z_req_addr = a; z_mem_read = r; z_mem_write = w; z_load_signed = s; z_write_data = d;
        z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (z_resp_valid) begin
                lat = i;
                break;
            end
        end
        q = z_resp_data;
        e = z_resp_err;
        @(negedge clk);
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        $display("txn0 addr=%h rd=%0d wr=%0d wdata=%h -> data=%h err=%0b lat=%0d",
                 a, r, w, d, q, e, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_init();
        logic [31:0] q, mq, d;
        logic e, me;
        int lat;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            issue(32'(i * 4), 2'b00, 2'b11, 1'b0, d, q, e, lat);
            model_access(32'(i * 4), 2'b00, 2'b11, 1'b0, d, me, mq);
            checks++; if (e !== me) begin errors++; $display("FAIL init_err[%0d]: got %b want %b", i, e, me); end
        end
    endtask

    task automatic test_store_load_word();
        logic [31:0] q, mq;
        logic e, me;
        int lat;
        issue(32'h10, 2'b00, 2'b11, 1'b0, 32'hDEADBEEF, q, e, lat);
        model_access(32'h10, 2'b00, 2'b11, 1'b0, 32'hDEADBEEF, me, mq);
        checks++; if (lat != 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
        checks++; if (e !== 1'b0 || q !== 32'h0) begin errors++; $display("FAIL sw_resp: got err=%b data=%h want err=0 data=0", e, q); end
        issue(32'h10, 2'b11, 2'b00, 1'b0, 32'h0, q, e, lat);
        model_access(32'h10, 2'b11, 2'b00, 1'b0, 32'h0, me, mq);
        checks++; if (lat != 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        checks++; if (q !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b want deadbeef err=0", q, e); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] q, mq;
        logic e, me;
        int lat;
        issue(32'h10, 2'b00, 2'b11, 1'b0, 32'h0, q, e, lat);
        model_access(32'h10, 2'b00, 2'b11, 1'b0, 32'h0, me, mq);
        issue(32'h11, 2'b00, 2'b01, 1'b0, 32'hAAAAAA80, q, e, lat);
        model_access(32'h11, 2'b00, 2'b01, 1'b0, 32'hAAAAAA80, me, mq);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sb_err: got %b want 0", e); end
        issue(32'h11, 2'b01, 2'b00, 1'b1, 32'h0, q, e, lat);
        checks++; if (q !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", q); end
        issue(32'h11, 2'b01, 2'b00, 1'b0, 32'h0, q, e, lat);
        checks++; if (q !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned: got %h want 00000080", q); end
        issue(32'h10, 2'b11, 2'b00, 1'b1, 32'h0, q, e, lat);
        checks++; if (q !== 32'h00008000) begin errors++; $display("FAIL lw_after_sb: got %h want 00008000", q); end
    endtask

    task automatic test_errors();
        logic [31:0] q, mq;
        logic e, me;
        int lat;
        logic [31:0] addrs [7] = '{32'h13, 32'h12, 32'h400, 32'h11, 32'h10, 32'h80000010, 32'h401};
        logic [1:0]  rds   [7] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01};
        logic [1:0]  wrs   [7] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            issue(addrs[i], rds[i], wrs[i], 1'b1, 32'h55AA55AA, q, e, lat);
            checks++; if (e !== 1'b1 || q !== 32'h0 || lat != 3) begin
                errors++; $display("FAIL err_case[%0d]: got err=%b data=%h lat=%0d want err=1 data=0 lat=3", i, e, q, lat);
            end
        end
        issue(32'h0, 2'b11, 2'b00, 1'b0, 32'h0, q, e, lat);
        model_access(32'h0, 2'b11, 2'b00, 1'b0, 32'h0, me, mq);
        checks++; if (q !== mq) begin errors++; $display("FAIL err_no_write: got %h want %h", q, mq); end
    endtask

    task automatic test_stall();
        logic [31:0] mq;
        logic me;
        int lat;
        model_access(32'h10, 2'b11, 2'b00, 1'b0, 32'h0, me, mq);
        @(negedge clk);
        req_addr = 32'h10; mem_read = 2'b11; mem_write = 2'b00; load_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 32'h20;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = i; break; end
        end
        checks++; if (lat != 3 || resp_data !== mq) begin errors++; $display("FAIL stall_resp: got lat=%0d data=%h want lat=3 data=%h", lat, resp_data, mq); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1 || resp_data !== mq || req_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h ready=%b want 1 %h 0", c, resp_valid, resp_data, req_ready, mq);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        $display("txn stall load addr=00000010 data=%h", mq);
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, mq;
        logic e, me;
        int lat;
        model_access(32'h20, 2'b11, 2'b00, 1'b0, 32'h0, me, mq);
        // Reset while BUSY.
        @(negedge clk);
        req_addr = 32'h20; mem_read = 2'b00; mem_write = 2'b11; write_data = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got ready=%b valid=%b data=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_data, resp_err);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(32'h20, 2'b11, 2'b00, 1'b0, 32'h0, q, e, lat);
        checks++; if (q !== mq) begin errors++; $display("FAIL midreset_mem: got %h want %h", q, mq); end
        // Reset on the response-entry edge.
        @(negedge clk);
        req_addr = 32'h20; mem_read = 2'b00; mem_write = 2'b11; write_data = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL entryreset_outputs: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(32'h20, 2'b11, 2'b00, 1'b0, 32'h0, q, e, lat);
        checks++; if (q !== mq) begin errors++; $display("FAIL entryreset_mem: got %h want %h", q, mq); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, q, mq;
        logic [1:0] r, w;
        logic s, e, me;
        int lat, kind;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            a = (kind == 0) ? $urandom : (kind == 1) ? 32'($urandom_range(1024, 2047))
                                                     : 32'($urandom_range(0, 1023));
            kind = $urandom_range(0, 19);
            if (kind < 9) begin r = 2'($urandom_range(1, 3)); w = 2'b00; end
            else if (kind < 18) begin r = 2'b00; w = 2'($urandom_range(1, 3)); end
            else begin r = 2'($urandom); w = 2'($urandom); end
            // Bias toward aligned addresses so most requests are legal.
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            s = 1'($urandom);
            d = $urandom;
            issue(a, r, w, s, d, q, e, lat);
            model_access(a, r, w, s, d, me, mq);
            checks++; if (lat != 3) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 3", i, lat); end
            checks++; if (e !== me) begin errors++; $display("FAIL rand_err[%0d]: addr=%h got %b want %b", i, a, e, me); end
            checks++; if (q !== mq) begin errors++; $display("FAIL rand_data[%0d]: addr=%h got %h want %h", i, a, q, mq); end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] q, d;
        logic e;
        int lat;
        d = $urandom;
        issue_z(32'h40, 2'b00, 2'b11, 1'b0, d, q, e, lat);
        checks++; if (lat != 1 || e !== 1'b0) begin errors++; $display("FAIL zw_store: got lat=%0d err=%b want 1 0", lat, e); end
        issue_z(32'h42, 2'b00, 2'b01, 1'b0, 32'h0000005A, q, e, lat);
        issue_z(32'h40, 2'b11, 2'b00, 1'b0, 32'h0, q, e, lat);
        d[23:16] = 8'h5A;
        checks++; if (lat != 1 || q !== d) begin errors++; $display("FAIL zw_load: got lat=%0d data=%h want 1 %h", lat, q, d); end
        issue_z(32'h40, 2'b01, 2'b01, 1'b0, 32'h0, q, e, lat);
        checks++; if (lat != 1 || e !== 1'b1 || q !== 32'h0) begin
            errors++; $display("FAIL zw_both_sizes: got lat=%0d err=%b data=%h want 1 1 0", lat, e, q);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0; mem_read = 2'b00; mem_write = 2'b00;
        load_signed = 1'b0; write_data = 32'h0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_addr = 32'h0; z_mem_read = 2'b00; z_mem_write = 2'b00;
        z_load_signed = 1'b0; z_write_data = 32'h0; z_resp_ready = 1'b0;
        test_reset();
        test_init();
        test_store_load_word();
        test_byte_lanes();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
